// File: rtl/demux2_deinterleave_if.sv
// rtl/demux2_deinterleave_if.sv - tagged sample input stream and paired lane output stream
interface demux2_deinterleave_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] d;
    logic             sel;
    logic             in_ready;
    logic [WIDTH-1:0] z0;
    logic [WIDTH-1:0] z1;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, d, sel, out_ready,
        input  in_ready, z0, z1, out_valid
    );

    modport slave (
        input  in_valid, d, sel, out_ready,
        output in_ready, z0, z1, out_valid
    );
endinterface

// File: rtl/demux2_deinterleave.sv
// rtl/demux2_deinterleave.sv - lane demultiplexer pairing lane0/lane1 samples; option DEMUX2_ORDER_CHECK_EN
module demux2_deinterleave #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux2_deinterleave_if.slave bus,
    output logic                 err,
    output logic [CNT_W-1:0]     pair_cnt
);
    typedef enum logic [1:0] {EMPTY, GOT0, GOT1, FULL} state_t;

    state_t state_q, state_d;
    logic   acc, hs;
    logic   wr0, wr1, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            bus.z0   <= '0;
            bus.z1   <= '0;
            err      <= 1'b0;
            pair_cnt <= '0;
        end else begin
            state_q <= state_d;
            err     <= err_d;
            if (wr0) bus.z0 <= bus.d;
            if (wr1) bus.z1 <= bus.d;
            if (hs)  pair_cnt <= pair_cnt + 1'b1;
        end
    end

    // An accept while FULL implies out_ready, so the pair retires in the same cycle.
    always_comb begin
        state_d = state_q;
        wr0     = 1'b0;
        wr1     = 1'b0;
        err_d   = 1'b0;
        acc     = bus.in_valid && bus.in_ready;
        hs      = bus.out_valid && bus.out_ready;
        case (state_q)
            EMPTY, FULL: begin
                if (state_q == FULL && hs) state_d = EMPTY;
                if (acc) begin
                    if (!bus.sel) begin
                        wr0     = 1'b1;
                        state_d = GOT0;
                    end else begin
`ifdef DEMUX2_ORDER_CHECK_EN
                        err_d   = 1'b1;
`else
                        wr1     = 1'b1;
                        state_d = GOT1;
`endif
                    end
                end
            end
            GOT0: begin
                if (acc) begin
                    if (bus.sel) begin
                        wr1     = 1'b1;
                        state_d = FULL;
                    end else begin
                        wr0   = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            GOT1: begin
                if (acc) begin
                    if (!bus.sel) begin
                        wr0     = 1'b1;
                        state_d = FULL;
                    end else begin
                        wr1   = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        bus.out_valid = (state_q == FULL);
        bus.in_ready  = (state_q != FULL) || bus.out_ready;
    end
endmodule

// File: tb/tb_demux2_deinterleave.sv
// tb/tb_demux2_deinterleave.sv - randomized and directed checks against a lane-flag model
module tb_demux2_deinterleave;
    localparam int WIDTH = 1;
    localparam int CNT_W = 8;
`ifdef DEMUX2_ORDER_CHECK_EN
    localparam bit ORDER = 1'b1;
`else
    localparam bit ORDER = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             err;
    logic [CNT_W-1:0] pair_cnt;

    demux2_deinterleave_if #(.WIDTH(WIDTH)) bus ();

    demux2_deinterleave #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .err      (err),
        .pair_cnt (pair_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int err_total = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        else passes++;
    endtask

    // Model: each lane either holds a sample or not; a pair is presented while both do.
    logic             m_has0, m_has1, m_err;
    logic [WIDTH-1:0] m_z0, m_z1;
    logic [CNT_W-1:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_has0 <= 1'b0; m_has1 <= 1'b0; m_err <= 1'b0;
            m_z0 <= '0; m_z1 <= '0; m_cnt <= '0;
        end else begin
            automatic bit full = m_has0 && m_has1;
            automatic bit acc = bus.in_valid && (!full || bus.out_ready);
            automatic bit h0 = m_has0, h1 = m_has1, e = 1'b0;
            if (full && bus.out_ready) begin
                h0 = 1'b0; h1 = 1'b0;
                m_cnt <= m_cnt + 1'b1;
            end
            if (acc) begin
                if (!bus.sel) begin
                    e = h0; h0 = 1'b1; m_z0 <= bus.d;
                end else if (ORDER && !h0) begin
                    e = 1'b1;
                end else begin
                    e = h1; h1 = 1'b1; m_z1 <= bus.d;
                end
            end
            m_has0 <= h0; m_has1 <= h1; m_err <= e;
        end
    end

    always @(negedge clk) begin
        if (rst_n) err_total <= err_total + int'(err);
        if (check_en && rst_n) begin
            chk("in_ready",  int'(bus.in_ready),  int'(!(m_has0 && m_has1) || bus.out_ready));
            chk("out_valid", int'(bus.out_valid), int'(m_has0 && m_has1));
            chk("z0",        int'(bus.z0),        int'(m_z0));
            chk("z1",        int'(bus.z1),        int'(m_z1));
            chk("err",       int'(err),           int'(m_err));
            chk("pair_cnt",  int'(pair_cnt),      int'(m_cnt));
        end
    end

    task automatic cyc(input bit v, input bit s, input bit dd, input bit ordy);
        bus.in_valid  = v;
        bus.sel       = s;
        bus.d         = WIDTH'(dd);
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.sel = 1'b0; bus.d = '0; bus.out_ready = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int e0;
        int stalls;
        do_reset();
        check_en = 1'b1;
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset pair_cnt", int'(pair_cnt), 0);
        chk("reset err", int'(err), 0);

        // reset mid-pair
        cyc(1, 0, 1, 0);
        chk("mid z0 captured", int'(bus.z0), 1);
        rst_n = 1'b0;
        #1;
        chk("async z0", int'(bus.z0), 0);
        chk("async out_valid", int'(bus.out_valid), 0);
        chk("async pair_cnt", int'(pair_cnt), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(1, 1, 1, 0);
        chk("after reset sel1 out_valid", int'(bus.out_valid), 0);
        chk("after reset sel1 z1", int'(bus.z1), ORDER ? 0 : 1);
        cyc(1, 0, 1, 0);
        chk("after reset completes", int'(bus.out_valid), ORDER ? 0 : 1);

        // basic pair plus back-pressure
        do_reset();
        cyc(1, 0, 1, 0);
        chk("basic not yet valid", int'(bus.out_valid), 0);
        cyc(1, 1, 0, 0);
        chk("basic out_valid", int'(bus.out_valid), 1);
        chk("basic z0", int'(bus.z0), 1);
        chk("basic z1", int'(bus.z1), 0);
        chk("basic in_ready", int'(bus.in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 0, 0);
            chk("hold z0", int'(bus.z0), 1);
            chk("hold z1", int'(bus.z1), 0);
            chk("hold valid", int'(bus.out_valid), 1);
        end
        cyc(1, 0, 0, 1);
        chk("retire+accept pair_cnt", int'(pair_cnt), 1);
        chk("retire+accept out_valid", int'(bus.out_valid), 0);
        chk("retire+accept z0", int'(bus.z0), 0);
        cyc(1, 1, 1, 0);
        chk("second pair valid", int'(bus.out_valid), 1);
        cyc(0, 0, 0, 1);
        chk("retire to empty pair_cnt", int'(pair_cnt), 2);
        chk("retire to empty valid", int'(bus.out_valid), 0);

        // reverse order
        do_reset();
        e0 = err_total;
        cyc(1, 1, 1, 0);
        cyc(1, 0, 1, 0);
        chk("reverse out_valid", int'(bus.out_valid), ORDER ? 0 : 1);
        chk("reverse z0", int'(bus.z0), 1);
        chk("reverse z1", int'(bus.z1), ORDER ? 0 : 1);
        @(negedge clk);
        chk("reverse err pulses", err_total - e0, ORDER ? 1 : 0);
        @(posedge clk); #1;

        // duplicate lane0
        do_reset();
        e0 = err_total;
        cyc(1, 0, 1, 0);
        chk("dup first no err", int'(err), 0);
        cyc(1, 0, 0, 0);
        chk("dup err", int'(err), 1);
        cyc(1, 1, 1, 0);
        chk("dup err cleared", int'(err), 0);
        chk("dup out_valid", int'(bus.out_valid), 1);
        chk("dup z0", int'(bus.z0), 0);
        chk("dup z1", int'(bus.z1), 1);
        @(negedge clk);
        chk("dup err pulses", err_total - e0, 1);
        @(posedge clk); #1;

        // streaming with wrap
        do_reset();
        e0 = err_total;
        stalls = 0;
        for (int i = 0; i < 512; i++) begin
            bus.in_valid = 1'b1; bus.sel = i[0]; bus.d = WIDTH'($urandom_range(0, 1));
            bus.out_ready = 1'b1;
            #1;
            if (!bus.in_ready) stalls++;
            @(posedge clk);
            #1;
        end
        chk("stream stalls", stalls, 0);
        chk("stream pair_cnt before last", int'(pair_cnt), 255);
        cyc(0, 0, 0, 1);
        chk("stream pair_cnt wrap", int'(pair_cnt), 0);
        @(negedge clk);
        chk("stream err pulses", err_total - e0, 0);
        @(posedge clk); #1;

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
        cyc(0, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/demux2_deinterleave.md
Name: demux2_deinterleave

Overview:
- Receiving end of the 2->1 mux path. A transmitter time-multiplexes two lanes onto one data line with a lane-select tag.
- This block demultiplexes each tagged sample back into its lane register, pairs lane0 and lane1 samples, and presents the pair with a valid/ready handshake.
- Sits directly downstream of the mux-based serializer. Feeds the parallel consumer.

Parameters:
- WIDTH, 1: bit width of each sample and of each lane output.
- CNT_W, 8: width of the pair counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  sample present on d/sel.
- d  input  WIDTH  multiplexed sample.
- sel  input  1  lane tag: 0 = lane0, 1 = lane1.
- in_ready  output  1  block can accept a sample this cycle.
- z0  output  WIDTH  lane0 register.
- z1  output  WIDTH  lane1 register.
- out_valid  output  1  z0/z1 hold a complete pair.
- out_ready  input  1  consumer accepts the pair.
- err  output  1  one-cycle pulse on a protocol error.
- pair_cnt  output  CNT_W  number of pairs delivered; wraps.

Behaviour:
- Reset (rst_n=0, asynchronous): state=EMPTY; z0=0, z1=0, out_valid=0, err=0, pair_cnt=0. in_ready=1 once rst_n=1. Reset mid-pair discards any captured lane.
- Accept condition: in_valid && in_ready. Output handshake: out_valid && out_ready.
- FSM states: EMPTY, GOT0, GOT1, FULL.
  - EMPTY: accept sel=0 -> z0<=d, GOT0. Accept sel=1 -> z1<=d, GOT1.
  - GOT0: accept sel=1 -> z1<=d, FULL. Accept sel=0 (duplicate) -> z0<=d overwritten, stay GOT0, err=1 next cycle.
  - GOT1: mirror of GOT0. Accept sel=0 -> z0<=d, FULL. Duplicate sel=1 -> overwrite z1, stay GOT1, err=1.
  - FULL: out_valid=1. z0/z1 stay stable until the output handshake.
- out_valid is registered: it rises the cycle after the completing sample is accepted. Minimum latency is 2 accepted samples, then +1 cycle.
- in_ready = (state != FULL) || out_ready. Combinational from out_ready; no other combinational path from inputs to outputs.
- Simultaneous events in FULL: output handshake plus accepted sample in the same cycle -> pair retired and the new sample written to its lane. Next state is GOT0 or GOT1 per sel. out_valid=0 next cycle.
- Output handshake without input -> EMPTY.
- In FULL with out_ready=0, in_ready=0 and samples are back-pressured (no drop).
- pair_cnt increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
- err is high for exactly one cycle per offending accepted sample. Back-to-back offences give back-to-back pulses.
- in_valid=0 causes no state change. d and sel are don't-care while in_valid=0.

Optional Feature:
- Macro DEMUX2_ORDER_CHECK_EN.
- Defined: strict lane order; a pair must arrive lane0 then lane1.
  - In EMPTY, an accepted sel=1 sample is dropped: z1 unchanged, state stays EMPTY, err pulses.
  - GOT1 is unreachable.
  - Duplicate sel=0 in GOT0 behaves as above (overwrite plus err).
- Undefined: either order is accepted as described in Behaviour.

Test Plan:
- Reset mid-pair: WIDTH=1; accept sel=0,d=1, then drop rst_n for 1 cycle -> z0=0, out_valid=0, pair_cnt=0. A following sel=1 sample lands in GOT1, not FULL.
- Basic pair: accept (sel=0,d=1) then (sel=1,d=0) with out_ready=0 -> out_valid=1 one cycle after the second accept; z0=1, z1=0; in_ready=0. Hold 5 cycles -> values stable. Raise out_ready -> pair_cnt=1, state EMPTY.
- Reverse order without macro: (sel=1,d=1) then (sel=0,d=1) -> z0=1, z1=1, out_valid=1, err never asserted. With DEMUX2_ORDER_CHECK_EN: the first sample is dropped, err pulses once, out_valid stays 0.
- Duplicate: (sel=0,d=1), (sel=0,d=0), (sel=1,d=1) -> exactly one err pulse, after the second accept; final pair z0=0, z1=1.
- Streaming with out_ready tied to 1 and in_valid held 1, sel toggling 0,1,0,1,... for 512 samples -> 256 pairs; pair_cnt wraps to 0 (CNT_W=8); no err. in_ready stays 1 in FULL because out_ready=1, so no input stall.
- Back-pressure: FULL with out_ready=0 and in_valid=1 for 3 cycles -> no samples consumed, z0/z1 unchanged. Releasing out_ready accepts the waiting sample in the same cycle the pair retires.
